huffman_seq: RTL and testbench

HUFFMAN_SEQ -- requirements
Module: huffman_seq

---
 rtl/huffman_seq.sv | 139 +++++++++++++
 tb/tb_huffman_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_seq.sv
// Sequencer for a Huffman tree builder and code generator: starts the builder, reloads and
// strobes the generator, and waits for its table. Optional wait timeout: HUFF_SEQ_TIMEOUT_EN.
module huffman_seq #(
   parameter int START_W = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic        Clk_in,
   input  logic        n_Rst,
   input  logic        Start,
   input  logic        Abort,
   input  logic        Build_done,
   input  logic        Fin,
   output logic        Start_build,
   output logic        n_Rst_code,
   output logic        Start_code,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic [15:0] Cycles
);

   typedef enum logic [2:0] {IDLE, BUILD, ARM, STRB, WAIT_FIN, DONE} state_t;

   localparam logic [3:0] STRB_LAST = 4'(START_W - 1);

   if (START_W < 1 || START_W > 15) begin : g_bad_start_w
      $error("huffman_seq: START_W must be 1..15");
   end
   if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
      $error("huffman_seq: TIMEOUT must be 1..1023");
   end

   state_t      state, state_nxt;
   logic [3:0]  strb_cnt;
   logic        first_q;
   logic        code_rdy_q, code_rdy_nxt;
   logic        accept;
   logic        timeout;
   logic [15:0] cycles_q;

   assign accept = (state == IDLE) && Start;

`ifdef HUFF_SEQ_TIMEOUT_EN
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

   logic [9:0] wait_cnt;
   logic       err_q;

   assign timeout = ((state == BUILD) || (state == WAIT_FIN)) && (wait_cnt == TO_LAST);

   // Counter restarts on every state change, so it reads 0 on the first BUILD/WAIT_FIN cycle.
   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst)
         wait_cnt <= 10'd0;
      else if (state_nxt != state)
         wait_cnt <= 10'd0;
      else if ((state == BUILD) || (state == WAIT_FIN))
         wait_cnt <= wait_cnt + 10'd1;
   end

   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst)
         err_q <= 1'b0;
      else if (accept)
         err_q <= 1'b0;
      else if (timeout && !Abort)
         err_q <= 1'b1;
   end

   assign Err = err_q;
`else
   assign timeout = 1'b0;
   assign Err     = 1'b0;
`endif

   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst) begin
         state      <= IDLE;
         first_q    <= 1'b0;
         code_rdy_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         first_q    <= accept;
         code_rdy_q <= code_rdy_nxt;
      end
   end

   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst)
         strb_cnt <= 4'd0;
      else if (state != STRB)
         strb_cnt <= 4'd0;
      else
         strb_cnt <= strb_cnt + 4'd1;
   end

   always_comb begin
      state_nxt    = state;
      code_rdy_nxt = 1'b0;
      case (state)
         IDLE:     if (Start) state_nxt = BUILD;
         BUILD:    if (Abort) state_nxt = IDLE;
                   else if (Build_done) state_nxt = ARM;
                   else if (timeout) state_nxt = IDLE;
         ARM:      state_nxt = Abort ? IDLE : STRB;
         STRB:     if (Abort) state_nxt = IDLE;
                   else if (strb_cnt == STRB_LAST) state_nxt = WAIT_FIN;
         WAIT_FIN: if (Abort) state_nxt = IDLE;
                   else if (Fin) state_nxt = DONE;
                   else if (timeout) state_nxt = IDLE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      // Generator stays out of reset after a clean finish; any other way into IDLE holds it in reset.
      case (state_nxt)
         STRB, WAIT_FIN, DONE: code_rdy_nxt = 1'b1;
         IDLE:    code_rdy_nxt = code_rdy_q && ((state == IDLE) || (state == DONE));
         default: code_rdy_nxt = 1'b0;
      endcase
   end

   assign Busy        = (state == BUILD) || (state == ARM) || (state == STRB) || (state == WAIT_FIN);
   assign Done        = (state == DONE);
   assign Start_code  = (state == STRB);
   assign Start_build = (state == BUILD) && first_q;
   assign n_Rst_code  = code_rdy_q;

   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst)
         cycles_q <= 16'd0;
      else if (accept)
         cycles_q <= 16'd0;
      else if (Busy && (cycles_q != 16'hFFFF))
         cycles_q <= cycles_q + 16'd1;
   end

   assign Cycles = cycles_q;

endmodule

// File: tb/tb_huffman_seq.sv
// Directed bench for huffman_seq: two instances (START_W=1 and 3) share stimulus and are
// checked every cycle against a phase/time model, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_huffman_seq;

   localparam int TO = 20;
`ifdef HUFF_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, bd = 1'b0, fin = 1'b0;
   logic sb1, nrc1, sc1, busy1, done1, err1;
   logic sb3, nrc3, sc3, busy3, done3, err3;
   logic [15:0] cyc1, cyc3;

   always #5 clk = ~clk;

   huffman_seq #(.START_W(1), .TIMEOUT(TO)) u1 (
      .Clk_in(clk), .n_Rst(rst_n), .Start(start), .Abort(abort), .Build_done(bd), .Fin(fin),
      .Start_build(sb1), .n_Rst_code(nrc1), .Start_code(sc1), .Busy(busy1), .Done(done1),
      .Err(err1), .Cycles(cyc1));

   huffman_seq #(.START_W(3), .TIMEOUT(TO)) u3 (
      .Clk_in(clk), .n_Rst(rst_n), .Start(start), .Abort(abort), .Build_done(bd), .Fin(fin),
      .Start_build(sb3), .n_Rst_code(nrc3), .Start_code(sc3), .Busy(busy3), .Done(done3),
      .Err(err3), .Cycles(cyc3));

   int nvec = 0, nbad = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ph: 0 idle, 1 build, 2 arm, 3 strobe, 4 wait fin, 5 done; k = cycles spent in phase
   typedef struct {
      int ph;
      int k;
      bit avail;
      int cyc;
      bit err;
   } mdl_t;

   mdl_t m1, m3;

   function automatic mdl_t step(input mdl_t m, input int sw, input bit st, input bit ab,
                                 input bit b, input bit f);
      mdl_t n;
      bit   busy;
      n    = m;
      busy = (m.ph >= 1) && (m.ph <= 4);
      if (busy) begin
         n.k = m.k + 1;
         if (m.cyc < 65535) n.cyc = m.cyc + 1;
      end
      case (m.ph)
         0: if (st) begin n.ph = 1; n.k = 0; n.cyc = 0; n.err = 0; n.avail = 0; end
         1: if (ab) n.ph = 0;
            else if (b) begin n.ph = 2; n.k = 0; end
            else if (TO_EN && m.k + 1 >= TO) begin n.ph = 0; n.err = 1; end
         2: if (ab) n.ph = 0; else begin n.ph = 3; n.k = 0; end
         3: if (ab) n.ph = 0; else if (m.k + 1 == sw) begin n.ph = 4; n.k = 0; end
         4: if (ab) n.ph = 0;
            else if (f) begin n.ph = 5; n.k = 0; end
            else if (TO_EN && m.k + 1 >= TO) begin n.ph = 0; n.err = 1; end
         default: begin n.ph = 0; n.avail = 1; end
      endcase
      if (busy && n.ph == 0) n.avail = 0;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= '{default: 0};
         m3 <= '{default: 0};
      end else begin
         m1 <= step(m1, 1, start, abort, bd, fin);
         m3 <= step(m3, 3, start, abort, bd, fin);
      end
   end

   task automatic chk_dut(input string t, input mdl_t m, input logic sb, input logic nrc,
                          input logic sc, input logic bz, input logic dn, input logic er,
                          input logic [15:0] cy);
      chk({t, ".Start_build"}, 16'(sb), 16'(m.ph == 1 && m.k == 0));
      chk({t, ".n_Rst_code"}, 16'(nrc), 16'(m.ph >= 3 || (m.ph == 0 && m.avail)));
      chk({t, ".Start_code"}, 16'(sc), 16'(m.ph == 3));
      chk({t, ".Busy"}, 16'(bz), 16'(m.ph >= 1 && m.ph <= 4));
      chk({t, ".Done"}, 16'(dn), 16'(m.ph == 5));
      chk({t, ".Err"}, 16'(er), 16'(m.err));
      chk({t, ".Cycles"}, cy, 16'(m.cyc));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk_dut("u1", m1, sb1, nrc1, sc1, busy1, done1, err1, cyc1);
         chk_dut("u3", m3, sb3, nrc3, sc3, busy3, done3, err3, cyc3);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string t, input logic sb, input logic nrc, input logic sc,
                                 input logic bz, input logic dn, input logic er,
                                 input logic [15:0] cy);
      chk({t, ".rst.Start_build"}, 16'(sb), 16'd0);
      chk({t, ".rst.n_Rst_code"}, 16'(nrc), 16'd0);
      chk({t, ".rst.Start_code"}, 16'(sc), 16'd0);
      chk({t, ".rst.Busy"}, 16'(bz), 16'd0);
      chk({t, ".rst.Done"}, 16'(dn), 16'd0);
      chk({t, ".rst.Err"}, 16'(er), 16'd0);
      chk({t, ".rst.Cycles"}, cy, 16'd0);
   endtask

   initial begin
      #3;
      chk_reset_vals("u1", sb1, nrc1, sc1, busy1, done1, err1, cyc1);
      #10 rst_n = 1'b1;

      // Reference run: Start at 0, Build_done at 5, Fin at 12
      tick; start = 1'b1;
      tick; start = 1'b0;
      chk("ref.u1.Start_build@1", 16'(sb1), 16'd1);
      chk("ref.u1.n_Rst_code@1", 16'(nrc1), 16'd0);
      chk("ref.u1.Busy@1", 16'(busy1), 16'd1);
      repeat (4) tick;
      bd = 1'b1;
      tick; bd = 1'b0;
      chk("ref.u1.n_Rst_code@6", 16'(nrc1), 16'd0);
      chk("ref.u1.Start_code@6", 16'(sc1), 16'd0);
      tick;
      chk("ref.u1.Start_code@7", 16'(sc1), 16'd1);
      chk("ref.u1.n_Rst_code@7", 16'(nrc1), 16'd1);
      chk("ref.u3.Start_code@7", 16'(sc3), 16'd1);
      tick;
      chk("ref.u1.Start_code@8", 16'(sc1), 16'd0);
      chk("ref.u3.Start_code@8", 16'(sc3), 16'd1);
      repeat (4) tick;
      fin = 1'b1;
      tick; fin = 1'b0;
      chk("ref.u1.Done@13", 16'(done1), 16'd1);
      chk("ref.u1.Busy@13", 16'(busy1), 16'd0);
      chk("ref.u1.Cycles@13", cyc1, 16'd12);
      chk("ref.u3.Cycles@13", cyc3, 16'd12);
      abort = 1'b1;
      tick; abort = 1'b0;
      chk("ref.u1.Done@14", 16'(done1), 16'd0);
      chk("ref.u1.n_Rst_code.hold", 16'(nrc1), 16'd1);

      // Wide strobe: Fin during the strobe is ignored
      tick; start = 1'b1;
      tick; start = 1'b0;
      repeat (2) tick;
      bd = 1'b1;
      tick; bd = 1'b0;
      tick;
      chk("strb.u3.Start_code@5", 16'(sc3), 16'd1);
      tick; fin = 1'b1;
      chk("strb.u3.Start_code@6", 16'(sc3), 16'd1);
      tick; fin = 1'b0;
      chk("strb.u3.Start_code@7", 16'(sc3), 16'd1);
      chk("strb.u1.Done@7", 16'(done1), 16'd1);
      tick;
      chk("strb.u3.Start_code@8", 16'(sc3), 16'd0);
      chk("strb.u3.Busy@8", 16'(busy3), 16'd1);
      fin = 1'b1;
      tick; fin = 1'b0;
      chk("strb.u3.Done@9", 16'(done3), 16'd1);
      abort = 1'b1;
      tick; abort = 1'b0;
      chk("strb.u3.n_Rst_code.abort_in_done", 16'(nrc3), 16'd1);

      // Abort and Fin together in WAIT_FIN
      tick; start = 1'b1;
      tick; start = 1'b0;
      tick; bd = 1'b1;
      tick; bd = 1'b0;
      repeat (4) tick;
      abort = 1'b1; fin = 1'b1;
      tick; abort = 1'b0; fin = 1'b0;
      chk("abort.u1.Busy", 16'(busy1), 16'd0);
      chk("abort.u1.Done", 16'(done1), 16'd0);
      chk("abort.u1.n_Rst_code", 16'(nrc1), 16'd0);
      chk("abort.u3.Done", 16'(done3), 16'd0);
      chk("abort.u3.n_Rst_code", 16'(nrc3), 16'd0);

      // Reset while strobing, then a clean run
      tick; start = 1'b1;
      tick; start = 1'b0; bd = 1'b1;
      tick; bd = 1'b0;
      tick;
      chk("rst.u3.Start_code.before", 16'(sc3), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("u1", sb1, nrc1, sc1, busy1, done1, err1, cyc1);
      chk_reset_vals("u3", sb3, nrc3, sc3, busy3, done3, err3, cyc3);
      #3 rst_n = 1'b1;
      tick; start = 1'b1;
      tick; start = 1'b0; bd = 1'b1;
      tick; bd = 1'b0;
      repeat (5) tick;
      fin = 1'b1;
      tick; fin = 1'b0;
      chk("rst.u1.Done.after", 16'(done1), 16'd1);
      chk("rst.u3.Done.after", 16'(done3), 16'd1);
      chk("rst.u1.Cycles.after", cyc1, 16'd7);

      // Long build with stray Starts: Cycles saturates
      tick; start = 1'b1;
      tick; start = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         start = (i % 1000 == 3);
         tick;
      end
      start = 1'b0;
`ifndef HUFF_SEQ_TIMEOUT_EN
      chk("sat.u1.Cycles", cyc1, 16'hFFFF);
      chk("sat.u1.Busy", 16'(busy1), 16'd1);
`endif
      bd = 1'b1;
      tick; bd = 1'b0;
      repeat (4) tick;
      fin = 1'b1;
      tick; fin = 1'b0;
      tick;

`ifdef HUFF_SEQ_TIMEOUT_EN
      // Build timeout after TO cycles in BUILD
      tick; start = 1'b1;
      tick; start = 1'b0;
      repeat (19) tick;
      chk("to.u1.Busy@20", 16'(busy1), 16'd1);
      chk("to.u1.Err@20", 16'(err1), 16'd0);
      tick;
      chk("to.u1.Err@21", 16'(err1), 16'd1);
      chk("to.u1.Busy@21", 16'(busy1), 16'd0);
      chk("to.u1.n_Rst_code@21", 16'(nrc1), 16'd0);
      start = 1'b1;
      tick; start = 1'b0;
      chk("to.u1.Err.cleared", 16'(err1), 16'd0);
      abort = 1'b1;
      tick; abort = 1'b0;
`endif

      repeat (3) tick;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
